// File: rtl/upg_load_ctrl.sv
// upg_load_ctrl: UART program/data loader and memory arbiter.
// Receives a frame {TGT, CNT_L, CNT_H, 4*N data bytes} and assembles
// little-endian 32-bit words. Each word is written one cycle after its
// last byte arrives. The CPU is held in reset while the loader owns memory.
// Optional feature macro: UPG_CHECKSUM_EN. When defined, an XOR checksum
// byte follows the data and must match before memory is handed back.
module upg_load_ctrl #(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned MAX_WORDS   = 16384,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              upg_wen_o,
  output logic [ADDR_W:0]   upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              cpu_rst_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int unsigned IDLE_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_TGT,
    S_HDR_CNTL,
    S_HDR_CNTH,
    S_DATA,
`ifdef UPG_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic                tgt_q;
  logic [15:0]         cnt_q;
  logic [ADDR_W-1:0]   word_idx_q;
  logic [1:0]          byte_cnt_q;
  logic [23:0]         asm_q;
  logic [IDLE_W-1:0]   idle_cnt_q;
  logic                drain_q;
  logic [15:0]         hdr_n;
  logic                data_byte;
  logic                word_last;
  logic                timeout_hit;
`ifdef UPG_CHECKSUM_EN
  logic [7:0]          chk_q;
`endif

  // Decoded per-cycle events shared by the FSM and the datapath
  always_comb begin
    hdr_n       = {rx_data_i, cnt_q[7:0]};
    data_byte   = (state_q == S_DATA) && rx_valid_i && !drain_q;
    word_last   = (32'(word_idx_q) + 32'd1) == 32'(cnt_q);
    timeout_hit = busy_o && !rx_valid_i && !drain_q &&
                  (idle_cnt_q == IDLE_W'(TIMEOUT_CYC - 1));
  end

  // Status outputs are pure functions of the current state
  always_comb begin
    busy_o = 1'b0;
    case (state_q)
      S_HDR_TGT, S_HDR_CNTL, S_HDR_CNTH, S_DATA: busy_o = 1'b1;
`ifdef UPG_CHECKSUM_EN
      S_CHK: busy_o = 1'b1;
`endif
      default: busy_o = 1'b0;
    endcase
    err_o      = (state_q == S_ERROR);
    upg_done_o = (state_q == S_IDLE) || (state_q == S_DONE);
    cpu_rst_o  = busy_o || err_o;
  end

  // Next-state logic; a timeout overrides any other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (start_i) state_d = S_HDR_TGT;
      S_HDR_TGT:  if (rx_valid_i) state_d = S_HDR_CNTL;
      S_HDR_CNTL: if (rx_valid_i) state_d = S_HDR_CNTH;
      S_HDR_CNTH:
        if (rx_valid_i) begin
          if (hdr_n == '0) begin
`ifdef UPG_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else if (32'(hdr_n) > MAX_WORDS) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA;
          end
        end
      S_DATA: begin
`ifdef UPG_CHECKSUM_EN
        if (data_byte && byte_cnt_q == 2'd3 && word_last) state_d = S_CHK;
`else
        // Stay in DATA through the final write pulse so memory is never
        // handed back while the last word is still being written.
        if (drain_q) state_d = S_DONE;
`endif
      end
`ifdef UPG_CHECKSUM_EN
      S_CHK: if (rx_valid_i) state_d = (rx_data_i == chk_q) ? S_DONE : S_ERROR;
`endif
      default: state_d = S_IDLE;
    endcase
    if (timeout_hit) state_d = S_ERROR;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Header capture, word assembly, write strobe and idle timer
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q      <= 1'b0;
      cnt_q      <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      idle_cnt_q <= '0;
      upg_wen_o  <= 1'b0;
      upg_adr_o  <= '0;
      upg_dat_o  <= '0;
`ifdef UPG_CHECKSUM_EN
      chk_q      <= '0;
`else
      drain_q    <= 1'b0;
`endif
    end else begin
      upg_wen_o <= data_byte && (byte_cnt_q == 2'd3);
`ifndef UPG_CHECKSUM_EN
      drain_q   <= data_byte && (byte_cnt_q == 2'd3) && word_last;
`endif
      if (upg_wen_o) word_idx_q <= word_idx_q + 1'b1;

      if (data_byte) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef UPG_CHECKSUM_EN
        chk_q      <= chk_q ^ rx_data_i;
`endif
        case (byte_cnt_q)
          2'd0: asm_q[7:0]   <= rx_data_i;
          2'd1: asm_q[15:8]  <= rx_data_i;
          2'd2: asm_q[23:16] <= rx_data_i;
          default: begin
            upg_dat_o <= {rx_data_i, asm_q};
            upg_adr_o <= {tgt_q, word_idx_q};
          end
        endcase
      end

      if (rx_valid_i) begin
        case (state_q)
          S_HDR_TGT:  tgt_q      <= rx_data_i[0];
          S_HDR_CNTL: cnt_q[7:0] <= rx_data_i;
          S_HDR_CNTH: begin
            cnt_q[15:8] <= rx_data_i;
            word_idx_q  <= '0;
            byte_cnt_q  <= '0;
`ifdef UPG_CHECKSUM_EN
            chk_q       <= '0;
`endif
          end
          default: ;
        endcase
      end

      if (!busy_o || rx_valid_i) idle_cnt_q <= '0;
      else                       idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end

`ifdef UPG_CHECKSUM_EN
  // Without a drain phase the final write overlaps the CHK state instead
  always_comb drain_q = 1'b0;
`endif

endmodule
